mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, beside the ALU, driven by the same A/B operand buses.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds results in architectural HI/LO registers, read downstream by MFHI/MFLO.
- Start/Busy/Done handshake lets the hazard unit stall the pipeline while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- Start  input  1  launch request, sampled on a rising clk edge while idle.
- MDOp  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  32  multiplicand / dividend.
- B  input  32  multiplier / divisor.
- Busy  output  1  operation in flight.
- Done  output  1  one-cycle pulse: HI/LO just updated.
- DivByZero  output  1  last completed divide had B==0; sticky until the next accepted Start.
- HI  output  32  product[63:32] / remainder.
- LO  output  32  product[31:0] / quotient.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - reset==0 forces state IDLE, Busy=0, Done=0, DivByZero=0, HI=0, LO=0, iteration counter=0, internal shift registers=0.
  - Reset mid-operation aborts the operation; HI/LO do not receive partial results.
- FSM states:
  - IDLE
    - Start==1 at an edge: latch A, B, MDOp; clear DivByZero; go to CALC.
    - Signed ops latch magnitudes |A|, |B| plus result-sign flags.
    - Start==0: stay in IDLE.
  - CALC
    - One iteration per cycle, counter 0..31; counter==31 moves to FIX.
    - Multiply: shift-add on a 64-bit accumulator.
    - Divide: restoring shift-subtract producing a 32-bit remainder and 32-bit quotient.
  - FIX
    - Apply sign correction and write HI/LO.
    - Register Done=1 and, for a divide with latched B==0, DivByZero=1.
    - Return to IDLE.
- Timing:
  - Busy=1 in every cycle after the accepting edge up to and including the FIX cycle (33 cycles); otherwise 0.
  - Done=1 for exactly the single cycle after the FIX edge (state IDLE, Busy=0).
  - Start is ignored while Busy=1.
  - Start asserted during the Done cycle is accepted: back-to-back operations are allowed.
  - HI/LO change only at the FIX edge and hold otherwise.
- Arithmetic rules:
  - MULTU: {HI,LO} = A*B, unsigned 64-bit.
  - MULT: two's-complement 64-bit product.
  - DIVU: LO = A/B, HI = A%B, unsigned.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no flag.
  - |0x80000000| is handled in 33-bit or unsigned form with no overflow in the magnitude path.
  - Divide by zero (either DIV or DIVU): full latency, LO=0xFFFFFFFF, HI=A (original signed/unsigned value unchanged), DivByZero=1.
- Operand buses may change after the accepting edge without affecting the operation.

Test Plan:
- Reset during CALC (cycle 10): assert reset=0 -> Busy=0, Done=0, HI=LO=0 immediately; after release, IDLE with no Done pulse.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done one cycle, 34 cycles after the Start edge; HI=0xFFFFFFFE, LO=0x00000001; Busy high exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, DivByZero=1. The next accepted Start clears DivByZero.
- Handshake edge cases:
  - Start pulsed while Busy -> ignored; the original result is unchanged.
  - Start held during the Done cycle with MULTU 3*5 -> second operation accepted; HI=0, LO=15 after a further 34 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide unit with HI/LO result registers
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [1:0]            MDOp,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0] opd;
    logic is_div, sgn_q, sgn_r, b_zero;

    logic a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0] mul_sum, div_diff;
    logic [2*W-1:0] mul_nxt, div_nxt, prod;
    logic [W-1:0] quo, rem;

    assign a_neg = MDOp[0] & A[W-1];
    assign b_neg = MDOp[0] & B[W-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_nxt = {mul_sum, acc[W-1:1]};
    // divide: acc = {partial remainder, dividend/quotient bits}, restoring shift-subtract
    assign div_diff = {acc[2*W-1:W], acc[W-1]} - {1'b0, opd};
    assign div_nxt = div_diff[W] ? {acc[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc[W-2:0], 1'b1};

    // a zero divisor leaves the remainder equal to |A| and quotient all ones; sign fixup restores A
    assign prod = sgn_q ? -acc : acc;
    assign quo = sgn_q ? -acc[W-1:0] : acc[W-1:0];
    assign rem = sgn_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    assign Busy = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    // next-state: accept while idle, 32 iterations, one fixup cycle
    always_comb begin
        state_nxt = (state == IDLE) ? (Start ? CALC : IDLE) :
                    (state == CALC) ? ((cnt == LAST) ? FIX : CALC) : IDLE;
    end

    // operand latch, iteration datapath and result write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            acc <= '0;
            opd <= '0;
            is_div <= 1'b0;
            sgn_q <= 1'b0;
            sgn_r <= 1'b0;
            b_zero <= 1'b0;
            Done <= 1'b0;
            DivByZero <= 1'b0;
            HI <= '0;
            LO <= '0;
        end else begin
            Done <= state == FIX;
            if (state == IDLE && Start) begin
                cnt <= '0;
                acc <= {{W{1'b0}}, MDOp[1] ? a_mag : b_mag};
                opd <= MDOp[1] ? b_mag : a_mag;
                is_div <= MDOp[1];
                sgn_q <= (a_neg ^ b_neg) & ~(MDOp[1] & ~|B);
                sgn_r <= a_neg;
                b_zero <= ~|B;
                DivByZero <= 1'b0;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= is_div ? div_nxt : mul_nxt;
            end else if (state == FIX) begin
                HI <= is_div ? rem : prod[2*W-1:W];
                LO <= is_div ? quo : prod[W-1:0];
                DivByZero <= is_div & b_zero;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [1:0] mdop = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic busy, done, dz;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .Start(start), .MDOp(mdop), .A(a), .B(b),
        .Busy(busy), .Done(done), .DivByZero(dz), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // result as {divbyzero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_calc(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'b00: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
            2'b01: begin p = sx * sy; return {1'b0, p}; end
            default: begin
                if (y == 0) return {1'b1, x, 32'hffffffff};
                if (op == 2'b10) return {1'b0, x % y, x / y};
                return {1'b0, 32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    // reference: 33 busy cycles per accepted op, results land with a one-cycle done pulse
    int m_rem = 0;
    logic m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [64:0] p_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_done <= 1'b0;
            m_dz <= 1'b0;
            m_hi <= '0;
            m_lo <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    p_res <= ref_calc(mdop, a, b);
                    m_dz <= 1'b0;
                    m_rem <= 33;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    {m_dz, m_hi, m_lo} <= p_res;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("divbyzero", {31'b0, dz}, {31'b0, m_dz});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic go(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        mdop = op;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        mdop = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        go(op, x, y);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout waited=%0d cycles required done pulse", lat);
        end
    endtask

    task automatic directed(input string nm, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int lat;
        logic [64:0] r;
        r = ref_calc(op, x, y);
        chk({nm, "_model_hi"}, r[63:32], eh);
        chk({nm, "_model_lo"}, r[31:0], el);
        start_op(op, x, y);
        wait_done(lat);
        chk({nm, "_latency"}, lat, 33);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_dz"}, {31'b0, dz}, {31'b0, ed});
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hffffffff;
            2: return 32'h80000000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, seen;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_dz", {31'b0, dz}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;

        directed("multu_max", 2'b00, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0);
        directed("mult_neg", 2'b01, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb, 1'b0);
        directed("div_neg", 2'b11, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, 1'b0);
        directed("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        directed("divu_zero", 2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hffffffff, 1'b1);
        start_op(2'b00, 32'd2, 32'd3);
        chk("dz_cleared_on_start", {31'b0, dz}, 0);
        wait_done(lat);
        directed("div_zero_neg", 2'b11, 32'h80000000, 32'h0, 32'h80000000, 32'hffffffff, 1'b1);
        directed("div_ovf", 2'b11, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0);

        start_op(2'b00, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        go(2'b10, 32'd9, 32'd0);
        wait_done(lat);
        chk("busy_ignore_hi", hi, 0);
        chk("busy_ignore_lo", lo, 42);
        chk("busy_ignore_dz", {31'b0, dz}, 0);

        start_op(2'b00, 32'd100, 32'd100);
        wait_done(lat);
        go(2'b00, 32'd3, 32'd5);
        wait_done(lat);
        chk("b2b_latency", lat, 33);
        chk("b2b_hi", hi, 0);
        chk("b2b_lo", lo, 15);

        start_op(2'b01, 32'hdeadbeef, 32'h12345);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);

        start_op(2'($urandom), rnd(), rnd());
        for (int i = 0; i < 150; i++) begin
            wait_done(lat);
            if ($urandom_range(0, 1) == 1) go(2'($urandom), rnd(), rnd());
            else start_op(2'($urandom), rnd(), rnd());
        end
        wait_done(lat);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
